alu_driver: RTL
===============

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameters SHALL be FIFO_DEPTH, 4, response FIFO entries (power of two, 2..16).
REQ-002 Parameters SHALL include ENC_KEY, 8'hAB, XOR key for ALU opcode ENC.
REQ-003 Port clk  in  1  sole clock; all state on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Ports cmd_valid in 1 / cmd_ready out 1 SHALL form the command handshake.
REQ-006 Ports cmd_a in 4, cmd_b in 4, cmd_op in 4 SHALL carry operands and opcode.
REQ-007 Port alu_ui out 8 SHALL drive ALU operand pins as {a,b}.
REQ-008 Port alu_uio out 8 SHALL drive {4'b0, opcode} to the ALU opcode pins.
REQ-009 Ports alu_uo in 8 and alu_flags in 2 SHALL carry the ALU result and {overflow, carry}.
REQ-010 Ports rsp_valid out 1 / rsp_ready in 1 SHALL form the response handshake.
REQ-011 Ports rsp_result out 8, rsp_op out 4, rsp_carry out 1, rsp_ovf out 1, rsp_err out 1 SHALL carry the response.
REQ-012 Port busy out 1 SHALL be high whenever the FSM is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, WAIT; IDLE->DRIVE on command accept, DRIVE->WAIT, WAIT->IDLE unconditionally.
REQ-014 cmd_ready SHALL equal (state==IDLE) && !fifo_full; accept = cmd_valid && cmd_ready.
REQ-015 On accept, alu_ui/alu_uio SHALL register the command and hold it through DRIVE and WAIT.
REQ-016 In IDLE, alu_uio SHALL drive opcode 4'hF and alu_ui SHALL drive 8'h00.
REQ-017 At the WAIT-exit edge, the response SHALL be pushed using alu_uo/alu_flags sampled then; rsp_valid rises 3 cycles after accept when the FIFO was empty.
REQ-018 rsp_carry/rsp_ovf SHALL take alu_flags only for ADD (0) and SUB (1); otherwise 0.
REQ-019 Opcodes 9..15 SHALL be driven unchanged, returned with rsp_result 8'h00, flags 0, rsp_err 1.
REQ-020 Responses SHALL leave the FIFO in command order; rsp_op echoes the opcode.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-022 Push SHALL never occur on a full FIFO (guaranteed by REQ-014); pop on empty SHALL be ignored.
REQ-023 Response payload SHALL be stable while rsp_valid && !rsp_ready.

Reset
REQ-024 rst SHALL force IDLE, empty FIFO, rsp_valid 0, all response fields 0, alu_ui 8'h00, alu_uio 8'h0F, busy 0.
REQ-025 rst during DRIVE or WAIT SHALL drop the in-flight command with no response produced.
REQ-026 cmd_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-027 Macro ALU_DRIVER_DECRYPT_EN defined: ENC (8) responses SHALL return alu_uo ^ ENC_KEY, and rsp_err SHALL be 1 if that differs from {a,b}.
REQ-028 Macro undefined: ENC responses SHALL return raw alu_uo with rsp_err 0; no decrypt logic present.

Structure
REQ-029 Package alu_drv_pkg SHALL hold opcode constants ADD..ENC, the FSM state enum and the default ENC_KEY.
REQ-030 The response FIFO SHALL be sub-module alu_drv_fifo (parameterised depth/width, count-based full/empty).
REQ-031 The bench SHALL connect alu_driver to the 4-bit ALU with uio[7:6] as alu_flags.

Verification
REQ-032 ADD a=9,b=8 -> rsp_result 8'h01, carry 1, ovf 1, rsp_valid 3 cycles after accept.
REQ-033 SUB a=3,b=5 -> rsp_result 8'h0E, carry 0, ovf 0; then AND a=F,b=3 -> 8'h03, flags 0.
REQ-034 ENC a=1,b=2 -> 8'h12, err 0 with ALU_DRIVER_DECRYPT_EN; 8'hB9, err 0 without.
REQ-035 rsp_ready=0, 5 back-to-back commands, depth 4 -> 4 accepted, cmd_ready low, then drained in order after rsp_ready=1.
REQ-036 Opcode 4'hA -> rsp_result 8'h00, err 1, flags 0.
REQ-037 rst pulsed during DRIVE -> no response, FIFO empty, cmd_ready 1 the cycle after release.

Source files
------------

// File: rtl/alu_drv_pkg.sv
// Shared opcode constants, FSM state type and response record for the ALU driver.
package alu_drv_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_ENC  = 4'd8;
    localparam logic [3:0] OP_IDLE = 4'hF;

    localparam logic [7:0] ENC_KEY_DEFAULT = 8'hAB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic [7:0] result;
        logic [3:0] op;
        logic       carry;
        logic       ovf;
        logic       err;
    } rsp_t;

endpackage

// File: rtl/alu_drv_fifo.sv
// Response FIFO: power-of-two depth, count-based full/empty, zeroed read data when empty.
module alu_drv_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Empty reads as zero so a freshly reset FIFO presents an all-zero response.
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_driver.sv
// Drives a 4-bit ALU one command at a time and queues its results as responses.
// Optional build macro ALU_DRIVER_DECRYPT_EN: decrypt ENC results with ENC_KEY and flag mismatches.
module alu_driver
    import alu_drv_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ENC_KEY    = ENC_KEY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic [7:0] alu_ui,
    output logic [7:0] alu_uio,
    input  logic [7:0] alu_uo,
    input  logic [1:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_op,
    output logic       rsp_carry,
    output logic       rsp_ovf,
    output logic       rsp_err,
    output logic       busy
);

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] alu_ab;
    logic [3:0] alu_op;
    logic [7:0] enc_result;
    logic       enc_err;
    rsp_t       rsp_push;
    rsp_t       rsp_head;

    function automatic rsp_t build_rsp(input logic [3:0] op, input logic [7:0] uo,
                                       input logic [1:0] flags, input logic [7:0] enc_res,
                                       input logic enc_bad);
        rsp_t r;
        r    = '0;
        r.op = op;
        case (op)
            OP_ADD, OP_SUB: begin
                r.result = uo;
                r.carry  = flags[0];
                r.ovf    = flags[1];
            end
            OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_NOT: r.result = uo;
            OP_ENC: begin
                r.result = enc_res;
                r.err    = enc_bad;
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = !fifo_full;
                accept    = cmd_valid && !fifo_full;
                if (accept) state_nxt = ST_DRIVE;
            end
            ST_DRIVE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                push      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU pins hold the command from accept until the result is captured, then park.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ab <= 8'h00;
            alu_op <= OP_IDLE;
        end else if (accept) begin
            alu_ab <= {cmd_a, cmd_b};
            alu_op <= cmd_op;
        end else if (push) begin
            alu_ab <= 8'h00;
            alu_op <= OP_IDLE;
        end
    end

    assign alu_ui  = alu_ab;
    assign alu_uio = {4'b0000, alu_op};

`ifdef ALU_DRIVER_DECRYPT_EN
    assign enc_result = alu_uo ^ ENC_KEY;
    assign enc_err    = (enc_result != alu_ab);
`else
    assign enc_result = alu_uo;
    assign enc_err    = 1'b0;
`endif

    assign rsp_push = build_rsp(alu_op, alu_uo, alu_flags, enc_result, enc_err);

    alu_drv_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rsp_push),
        .pop       (pop),
        .pop_data  (rsp_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid  = !fifo_empty;
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_result = rsp_head.result;
    assign rsp_op     = rsp_head.op;
    assign rsp_carry  = rsp_head.carry;
    assign rsp_ovf    = rsp_head.ovf;
    assign rsp_err    = rsp_head.err;

endmodule
